// File: rtl/softmax_pkg.sv
// Shared parameters and types for the softmax datapath packer/unpacker blocks.
package softmax_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int PACKET_NUM   = 8;
    localparam int PACKET_WIDTH = DATA_WIDTH * PACKET_NUM;
    localparam int IDX_WIDTH    = $clog2(PACKET_NUM);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Select word idx of a packet; word 0 lives in the low bits.
    function automatic logic [DATA_WIDTH-1:0] word_sel(
        input logic [PACKET_WIDTH-1:0] pkt,
        input logic [IDX_WIDTH-1:0]    idx
    );
        return pkt[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/data_unpacker.sv
// Serializes 128-bit packets into 16-bit words behind a show-ahead FIFO read port,
// with a one-packet holding slot so consecutive packets stream without bubbles.
module data_unpacker
    import softmax_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [PACKET_WIDTH-1:0] data_in,
    output logic                    ready,
    output logic                    overflow,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_empty,
    input  logic                    tx_fifo_en
);

    state_t                  state_r,  state_s;
    logic [PACKET_WIDTH-1:0] active_r, active_s;
    logic [PACKET_WIDTH-1:0] pend_r,   pend_s;
    logic [IDX_WIDTH-1:0]    idx_r,    idx_s;
    logic                    pend_v_r, pend_v_s;
    logic                    pop_s, last_pop_s, accept_s;
    logic [DATA_WIDTH-1:0]   tx_data_s;

    logic                    ready_r;
    logic                    overflow_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic                    tx_empty_r;

    // Next-state logic for the active/pending slots and the word index.
    always_comb begin
        state_s    = state_r;
        active_s   = active_r;
        pend_s     = pend_r;
        idx_s      = idx_r;
        pend_v_s   = pend_v_r;
        pop_s      = tx_fifo_en && (state_r == DRAIN);
        last_pop_s = pop_s && (idx_r == IDX_WIDTH'(PACKET_NUM - 1));
        accept_s   = valid && !pend_v_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    active_s = data_in;
                    idx_s    = {IDX_WIDTH{1'b0}};
                    state_s  = DRAIN;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRAIN: begin
                if (last_pop_s) begin
                    idx_s = {IDX_WIDTH{1'b0}};
                    // A held packet takes priority; a valid seen now is dropped by ready=0.
                    if (pend_v_r) begin
                        active_s = pend_r;
                        pend_v_s = 1'b0;
                    end else if (accept_s) begin
                        active_s = data_in;
                    end else begin
                        state_s  = IDLE;
                    end
                end else begin
                    if (pop_s) begin
                        idx_s = idx_r + IDX_WIDTH'(1);
                    end else begin
                        idx_s = idx_r;
                    end
                    if (accept_s) begin
                        pend_s   = data_in;
                        pend_v_s = 1'b1;
                    end else begin
                        pend_v_s = pend_v_r;
                    end
                end
            end
            default: begin
                state_s  = IDLE;
                idx_s    = {IDX_WIDTH{1'b0}};
                pend_v_s = 1'b0;
            end
        endcase

        if (state_s == DRAIN) begin
            tx_data_s = word_sel(active_s, idx_s);
        end else begin
            tx_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // State and output registers; outputs are derived from next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            active_r   <= {PACKET_WIDTH{1'b0}};
            pend_r     <= {PACKET_WIDTH{1'b0}};
            idx_r      <= {IDX_WIDTH{1'b0}};
            pend_v_r   <= 1'b0;
            ready_r    <= 1'b1;
            overflow_r <= 1'b0;
            tx_data_r  <= {DATA_WIDTH{1'b0}};
            tx_empty_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            active_r   <= active_s;
            pend_r     <= pend_s;
            idx_r      <= idx_s;
            pend_v_r   <= pend_v_s;
            ready_r    <= !pend_v_s;
            overflow_r <= valid && pend_v_r;
            tx_data_r  <= tx_data_s;
            tx_empty_r <= (state_s == IDLE);
        end
    end

    assign ready    = ready_r;
    assign overflow = overflow_r;
    assign tx_data  = tx_data_r;
    assign tx_empty = tx_empty_r;

endmodule

// File: tb/tb_data_unpacker.sv
// Scoreboard bench for data_unpacker: directed scenarios followed by random traffic.
module tb_data_unpacker;
    import softmax_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    valid = 1'b0;
    logic [PACKET_WIDTH-1:0] data_in = '0;
    logic                    ready;
    logic                    overflow;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_empty;
    logic                    tx_fifo_en = 1'b0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference: every accepted word sits in one FIFO; the unit holds at most two packets,
    // so the holding slot is busy exactly when more than one packet's worth is held.
    logic [DATA_WIDTH-1:0] exp_q[$];
    bit                    ov_exp = 1'b0;

    data_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .data_in    (data_in),
        .ready      (ready),
        .overflow   (overflow),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty),
        .tx_fifo_en (tx_fifo_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare visible outputs against the model, then advance the model on this edge's inputs.
    always @(negedge clk) begin
        if (mon_en) begin
            check("tx_empty", 32'(tx_empty), 32'(exp_q.size() == 0));
            check("ready", 32'(ready), 32'(exp_q.size() <= PACKET_NUM));
            check("overflow", 32'(overflow), 32'(ov_exp));
            if (exp_q.size() == 0) check("tx_data_idle", 32'(tx_data), 32'h0);
            else                   check("tx_data", 32'(tx_data), 32'(exp_q[0]));

            if (rst) begin
                exp_q.delete();
                ov_exp = 1'b0;
            end else begin
                bit acc;
                acc    = valid && (exp_q.size() <= PACKET_NUM);
                ov_exp = valid && (exp_q.size() > PACKET_NUM);
                if (tx_fifo_en && exp_q.size() > 0) void'(exp_q.pop_front());
                if (acc) begin
                    for (int w = 0; w < PACKET_NUM; w++)
                        exp_q.push_back(data_in[w*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [PACKET_WIDTH-1:0] d, input bit en);
        @(posedge clk);
        #1;
        valid      = v;
        data_in    = d;
        tx_fifo_en = en;
    endtask

    function automatic logic [PACKET_WIDTH-1:0] seq_pkt(input logic [11:0] base);
        logic [PACKET_WIDTH-1:0] p;
        for (int w = 0; w < PACKET_NUM; w++)
            p[w*DATA_WIDTH +: DATA_WIDTH] = {base, 4'(w)};
        return p;
    endfunction

    function automatic logic [PACKET_WIDTH-1:0] rnd_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;

        // Single packet, words 0000..0007
        cyc(1'b1, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 1'b1);
        repeat (10) cyc(1'b0, '0, 1'b1);

        // Back-to-back packets
        cyc(1'b1, seq_pkt(12'hAAA), 1'b1);
        cyc(1'b1, seq_pkt(12'hBBB), 1'b1);
        repeat (18) cyc(1'b0, '0, 1'b1);

        // Stall pattern 1,0,0,1,...
        cyc(1'b1, seq_pkt(12'hCCC), 1'b1);
        for (int i = 0; i < 30; i++) cyc(1'b0, '0, (i % 3) == 0);

        // Overflow: three packets with no pops
        cyc(1'b1, seq_pkt(12'h111), 1'b0);
        cyc(1'b1, seq_pkt(12'h222), 1'b0);
        cyc(1'b1, seq_pkt(12'h333), 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0);
        repeat (20) cyc(1'b0, '0, 1'b1);

        // Pop while empty, then a fresh packet
        repeat (10) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, seq_pkt(12'h444), 1'b1);
        repeat (10) cyc(1'b0, '0, 1'b1);

        // Reset mid-drain with a packet pending; valid during reset is ignored
        cyc(1'b1, seq_pkt(12'h555), 1'b0);
        cyc(1'b1, seq_pkt(12'h666), 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, seq_pkt(12'h777), 1'b1);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, seq_pkt(12'h888), 1'b1);
        repeat (10) cyc(1'b0, '0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) == 0), rnd_pkt(), ($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0;
        repeat (20) cyc(1'b0, '0, 1'b1);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
